proc_control_fsm: RTL and testbench

- Multi-cycle control sequencer for the 10-bit processor; sits directly upstream of the negedge datapath registers (register file, A, G, IR flip-flops).
- Latches an instruction word from DIN, steps through timing states T0–T3, and drives the one-hot load (`*_IN`) and bus-select (`*_OUT`) enables that those flip-flops consume on the same CLKb edge.

---
 rtl/proc_pkg.sv | 46 ++++
 rtl/proc_control_fsm_if.sv | 37 +++
 rtl/dec3to8.sv | 14 +
 rtl/proc_control_fsm.sv | 146 ++++++++++++++
 tb/tb_proc_control_fsm.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and instruction field positions for the 10-bit processor
package proc_pkg;

  localparam int W       = 10;
  localparam int NREG    = 8;
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;
  localparam int RX_LSB  = 3;
  localparam int RY_LSB  = 0;

  typedef enum logic [3:0] {
    OP_MV  = 4'd0,
    OP_MVI = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5
  } opcode_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_op_e;

  function automatic logic [2:0] rx_of(input logic [W-1:0] ir);
    return ir[RX_LSB+2:RX_LSB];
  endfunction

  function automatic logic [2:0] ry_of(input logic [W-1:0] ir);
    return ir[RY_LSB+2:RY_LSB];
  endfunction

  function automatic logic [3:0] opc_of(input logic [W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/proc_control_fsm_if.sv
// rtl/proc_control_fsm_if.sv - sequencer/datapath control bundle; ERR present only with ILLEGAL_TRAP_EN
interface proc_control_fsm_if;
  import proc_pkg::*;

  logic            RUN;
  logic [W-1:0]    DIN;
  logic            IR_IN;
  logic [NREG-1:0] R_IN;
  logic [NREG-1:0] R_OUT;
  logic            A_IN;
  logic            G_IN;
  logic            G_OUT;
  logic            DIN_OUT;
  logic [2:0]      ALU_OP;
  logic            DONE;
  logic [1:0]      STEP;
`ifdef ILLEGAL_TRAP_EN
  logic            ERR;
`endif

  modport master (
`ifdef ILLEGAL_TRAP_EN
    output ERR,
`endif
    input  RUN, DIN,
    output IR_IN, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT, ALU_OP, DONE, STEP
  );

  modport slave (
`ifdef ILLEGAL_TRAP_EN
    input  ERR,
`endif
    output RUN, DIN,
    input  IR_IN, R_IN, R_OUT, A_IN, G_IN, G_OUT, DIN_OUT, ALU_OP, DONE, STEP
  );

endinterface

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - 3-to-8 one-hot decoder with enable for register selects
module dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);

  // One-hot of sel when enabled, otherwise all zero
  always_comb begin
    y = 8'h00;
    if (en) y = 8'h01 << sel;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// rtl/proc_control_fsm.sv - T0..T3 control sequencer; ILLEGAL_TRAP_EN turns undefined opcodes into a sticky halt
module proc_control_fsm
  import proc_pkg::*;
(
  input  logic               CLKb,
  input  logic               RST,
  proc_control_fsm_if.master ctl
);

  step_e        step_q, step_d;
  logic [W-1:0] ir_q, ir_d;
`ifdef ILLEGAL_TRAP_EN
  logic         halt_q, halt_d;
`endif

  logic         rin_en, rout_en;
  logic [2:0]   rin_sel, rout_sel;
  opcode_e      opc;

  assign opc = opcode_e'(opc_of(ir_q));

  // State and instruction register; the datapath shares this negedge
  always_ff @(negedge CLKb) begin
    if (RST) begin
      step_q <= T0;
      ir_q   <= '0;
`ifdef ILLEGAL_TRAP_EN
      halt_q <= 1'b0;
`endif
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
`ifdef ILLEGAL_TRAP_EN
      halt_q <= halt_d;
`endif
    end
  end

  // Next state and enables; everything stays 0 while RST is high
  always_comb begin
    step_d      = step_q;
    ir_d        = ir_q;
`ifdef ILLEGAL_TRAP_EN
    halt_d      = halt_q;
`endif
    rin_en      = 1'b0;
    rin_sel     = 3'd0;
    rout_en     = 1'b0;
    rout_sel    = 3'd0;
    ctl.IR_IN   = 1'b0;
    ctl.A_IN    = 1'b0;
    ctl.G_IN    = 1'b0;
    ctl.G_OUT   = 1'b0;
    ctl.DIN_OUT = 1'b0;
    ctl.ALU_OP  = 3'd0;
    ctl.DONE    = 1'b0;

    if (!RST) begin
      case (step_q)
        T0: begin
          ctl.IR_IN = ctl.RUN;
          if (ctl.RUN) begin
            ir_d   = ctl.DIN;
            step_d = T1;
          end
        end
        T1: begin
`ifdef ILLEGAL_TRAP_EN
          if (halt_q) begin
            step_d = T1;
          end else
`endif
          case (opc)
            OP_MV: begin
              rout_en  = 1'b1;
              rout_sel = ry_of(ir_q);
              rin_en   = 1'b1;
              rin_sel  = rx_of(ir_q);
              ctl.DONE = 1'b1;
              step_d   = T0;
            end
            OP_MVI: begin
              ctl.DIN_OUT = 1'b1;
              rin_en      = 1'b1;
              rin_sel     = rx_of(ir_q);
              ctl.DONE    = 1'b1;
              step_d      = T0;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              rout_en  = 1'b1;
              rout_sel = rx_of(ir_q);
              ctl.A_IN = 1'b1;
              step_d   = T2;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
              halt_d   = 1'b1;
              step_d   = T1;
`else
              ctl.DONE = 1'b1;
              step_d   = T0;
`endif
            end
          endcase
        end
        T2: begin
          rout_en  = 1'b1;
          rout_sel = ry_of(ir_q);
          ctl.G_IN = 1'b1;
          case (opc)
            OP_SUB:  ctl.ALU_OP = ALU_SUB;
            OP_AND:  ctl.ALU_OP = ALU_AND;
            OP_OR:   ctl.ALU_OP = ALU_OR;
            default: ctl.ALU_OP = ALU_ADD;
          endcase
          step_d = T3;
        end
        default: begin
          ctl.G_OUT = 1'b1;
          rin_en    = 1'b1;
          rin_sel   = rx_of(ir_q);
          ctl.DONE  = 1'b1;
          step_d    = T0;
        end
      endcase
    end
  end

  assign ctl.STEP = RST ? T0 : step_q;
`ifdef ILLEGAL_TRAP_EN
  assign ctl.ERR  = halt_q & ~RST;
`endif

  dec3to8 u_rin_dec (
    .sel (rin_sel),
    .en  (rin_en),
    .y   (ctl.R_IN)
  );

  dec3to8 u_rout_dec (
    .sel (rout_sel),
    .en  (rout_en),
    .y   (ctl.R_OUT)
  );

endmodule

// File: tb/tb_proc_control_fsm.sv
// tb/tb_proc_control_fsm.sv - table-driven checks of the control sequencer
module tb_proc_control_fsm;

  logic CLKb;
  logic RST;

  proc_control_fsm_if ctl_if ();

  proc_control_fsm dut (
    .CLKb (CLKb),
    .RST  (RST),
    .ctl  (ctl_if)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  typedef struct {
    logic        rst;
    logic        run;
    logic [9:0]  din;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [26:0] act;
  assign act = {ctl_if.IR_IN, ctl_if.R_IN, ctl_if.R_OUT, ctl_if.A_IN, ctl_if.G_IN,
                ctl_if.G_OUT, ctl_if.DIN_OUT, ctl_if.ALU_OP, ctl_if.DONE, ctl_if.STEP};

  function automatic logic [26:0] ex(input logic ir_in, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic a, input logic g,
                                     input logic gout, input logic dout, input logic [2:0] alu,
                                     input logic done, input logic [1:0] st);
    return {ir_in, rin, rout, a, g, gout, dout, alu, done, st};
  endfunction

  function automatic vec_t mk(input logic rst, input logic run, input logic [9:0] din,
                              input logic [26:0] e);
    vec_t v;
    v.rst = rst; v.run = run; v.din = din; v.exp = e;
    return v;
  endfunction

  // Drive inputs mid-high-phase, well away from the active negedge
  task automatic drive(input logic rst, input logic run, input logic [9:0] din);
    @(posedge CLKb);
    RST        = rst;
    ctl_if.RUN = run;
    ctl_if.DIN = din;
    #2;
  endtask

  task automatic check(input string name, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  int done_cnt;
  int first_done;

  initial begin
    RST        = 1'b1;
    ctl_if.RUN = 1'b0;
    ctl_if.DIN = '0;

    // reset with RUN high, release with RUN low
    vecs.push_back(mk(1, 1, 10'h058, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(1, 1, 10'h058, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h058, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h058, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    // mvi R3, #155
    vecs.push_back(mk(0, 1, 10'h058, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h155, ex(0, 8'h08, 8'h00, 0, 0, 0, 1, 3'd0, 1, 2'd1)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    // sub R2, R5
    vecs.push_back(mk(0, 1, 10'h0D5, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h04, 1, 0, 0, 0, 3'd0, 0, 2'd1)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h20, 0, 1, 0, 0, 3'd1, 0, 2'd2)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h04, 8'h00, 0, 0, 1, 0, 3'd0, 1, 2'd3)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    // RUN held: mv R1,R7 then add R0,R0 back-to-back
    vecs.push_back(mk(0, 1, 10'h00F, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 1, 10'h080, ex(0, 8'h02, 8'h80, 0, 0, 0, 0, 3'd0, 1, 2'd1)));
    vecs.push_back(mk(0, 1, 10'h080, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 1, 10'h080, ex(0, 8'h00, 8'h01, 1, 0, 0, 0, 3'd0, 0, 2'd1)));
    vecs.push_back(mk(0, 1, 10'h080, ex(0, 8'h00, 8'h01, 0, 1, 0, 0, 3'd0, 0, 2'd2)));
    vecs.push_back(mk(0, 1, 10'h080, ex(0, 8'h01, 8'h00, 0, 0, 1, 0, 3'd0, 1, 2'd3)));
    vecs.push_back(mk(0, 0, 10'h080, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    // add aborted by reset in T2
    vecs.push_back(mk(0, 1, 10'h080, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h01, 1, 0, 0, 0, 3'd0, 0, 2'd1)));
    vecs.push_back(mk(1, 1, 10'h000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    // or R6, R1
    vecs.push_back(mk(0, 1, 10'h171, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h40, 1, 0, 0, 0, 3'd0, 0, 2'd1)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h02, 0, 1, 0, 0, 3'd3, 0, 2'd2)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h40, 8'h00, 0, 0, 1, 0, 3'd0, 1, 2'd3)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
`ifndef ILLEGAL_TRAP_EN
    // undefined opcode 1010 is a NOP
    vecs.push_back(mk(0, 1, 10'h280, ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 1, 2'd1)));
    vecs.push_back(mk(0, 0, 10'h000, ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0)));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // RUN held on mv R1,R2: DONE every second cycle, first one within a bounded wait
    drive(1, 0, 10'h00A);
    done_cnt   = 0;
    first_done = -1;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 10'h00A);
      if (ctl_if.DONE) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
    end
    checks++;
    if (first_done != 1) begin
      errors++;
      $display("FAIL mv_first_done actual=%0d required=1", first_done);
    end
    checks++;
    if (done_cnt != 3) begin
      errors++;
      $display("FAIL mv_done_count actual=%0d required=3", done_cnt);
    end
    drive(1, 0, 10'h000);
    check("reset_after_stream", ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0));

`ifdef ILLEGAL_TRAP_EN
    // undefined opcode parks the FSM in T1 with ERR set until reset
    drive(0, 1, 10'h280);
    check("trap_fetch", ex(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0));
    drive(0, 1, 10'h000);
    check("trap_t1", ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd1));
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 10'h058);
      check($sformatf("trap_hold%0d", c), ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd1));
      checks++;
      if (ctl_if.ERR !== 1'b1) begin
        errors++;
        $display("FAIL trap_err%0d actual=%b required=1", c, ctl_if.ERR);
      end
    end
    drive(1, 0, 10'h000);
    drive(0, 0, 10'h000);
    check("trap_cleared", ex(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0, 2'd0));
    checks++;
    if (ctl_if.ERR !== 1'b0) begin
      errors++;
      $display("FAIL trap_err_clear actual=%b required=0", ctl_if.ERR);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
